// File: rtl/seq_booth_multiplier_if.sv
// Start/done handshake bundle for the sequential Booth multiplier.
// master drives the request, slave returns status and the registered product.
interface seq_booth_multiplier_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic               signed_mode;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, signed_mode, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, signed_mode, multiplicand, multiplier,
    output busy, done, product
  );
endinterface

// File: rtl/seq_booth_multiplier.sv
// Multi-cycle radix-4 Booth multiplier, one digit per clock.
// Optional BOOTH_ZERO_BYPASS_EN: zero operands finish in one cycle.
module seq_booth_multiplier #(
  parameter int WIDTH = 32
) (
  input logic                  clk,
  input logic                  clr,
  seq_booth_multiplier_if.slave mul
);
  localparam int E  = WIDTH + 2;
  localparam int N  = E / 2;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t             state;
  state_t             state_n;
  logic [2*E-1:0]     acc;
  logic [2*E-1:0]     acc_sum;
  logic [2*E-1:0]     acc_n;
  logic [E:0]         q;
  logic [E-1:0]       m;
  logic [E-1:0]       pp;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] product;
  logic               busy;
  logic               done;
  logic               accept;
  logic               last;
  logic               skip;
  logic [E-1:0]       m_ext;
  logic [E-1:0]       q_ext;

  assign accept = mul.start && (state != RUN);
  assign last   = (state == RUN) && (cnt == CW'(N - 1));

`ifdef BOOTH_ZERO_BYPASS_EN
  assign skip = (mul.multiplicand == '0) ||
                (mul.multiplier == '0);
`else
  assign skip = 1'b0;
`endif

  // Two extra bits keep unsigned operands positive in E-bit two's complement.
  assign m_ext = {{2{mul.signed_mode & mul.multiplicand[WIDTH-1]}},
                  mul.multiplicand};
  assign q_ext = {{2{mul.signed_mode & mul.multiplier[WIDTH-1]}},
                  mul.multiplier};

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, DONE: begin
        if (accept) begin
          state_n = skip ? DONE : RUN;
        end else begin
          state_n = IDLE;
        end
      end
      RUN: begin
        state_n = last ? DONE : RUN;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  always_comb begin
    pp = '0;
    unique case (q[2:0])
      3'b001, 3'b010: pp = m;
      3'b011:         pp = m << 1;
      3'b100:         pp = -(m << 1);
      3'b101, 3'b110: pp = -m;
      default:        pp = '0;
    endcase
  end

  assign acc_sum = {acc[2*E-1:E] + pp, acc[E-1:0]};
  assign acc_n   = $signed(acc_sum) >>> 2;

  always_ff @(posedge clk) begin
    if (clr) begin
      acc     <= '0;
      q       <= '0;
      m       <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (accept) begin
      acc <= '0;
      cnt <= '0;
      m   <= m_ext;
      q   <= {q_ext, 1'b0};
      if (skip) begin
        product <= '0;
      end
    end else if (state == RUN) begin
      acc <= acc_n;
      q   <= $signed(q) >>> 2;
      cnt <= cnt + CW'(1);
      if (last) begin
        product <= acc_n[2*WIDTH-1:0];
      end
    end
  end

  assign mul.busy    = busy;
  assign mul.done    = done;
  assign mul.product = product;
endmodule

// File: tb/tb_seq_booth_multiplier.sv
// Self-checking bench for seq_booth_multiplier (WIDTH=32).
// Random and corner operands checked against a plain-arithmetic product model.
module tb_seq_booth_multiplier;
  localparam int W = 32;
  localparam int NLAT = 17;

  logic clk;
  logic clr;
  int   total;
  int   bad;

  seq_booth_multiplier_if #(.WIDTH(W)) mul_if ();

  seq_booth_multiplier #(.WIDTH(W)) dut (
    .clk (clk),
    .clr (clr),
    .mul (mul_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        s
  );
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = 64'(a);
    ub = 64'(b);
    return ua * ub;
  endfunction

  function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef BOOTH_ZERO_BYPASS_EN
    if (a == 0 || b == 0) return 0;
`endif
    return NLAT;
  endfunction

  task automatic accept(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        s
  );
    mul_if.start        = 1'b1;
    mul_if.multiplicand = a;
    mul_if.multiplier   = b;
    mul_if.signed_mode  = s;
    @(posedge clk);
    #1;
    mul_if.start        = 1'b0;
    mul_if.multiplicand = $urandom;
    mul_if.multiplier   = $urandom;
    mul_if.signed_mode  = 1'($urandom);
  endtask

  task automatic wait_done(output int lat, output logic busy_seen);
    lat = 0;
    busy_seen = 1'b0;
    while (mul_if.done !== 1'b1 && lat < 60) begin
      if (mul_if.busy === 1'b1) busy_seen = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        s,
    input  string       name
  );
    int   lat;
    logic bs;
    logic [63:0] exp_p;
    exp_p = ref_mul(a, b, s);
    accept(a, b, s);
    wait_done(lat, bs);
    total++;
    if (lat !== exp_lat(a, b)) begin
      bad++;
      $display("FAIL %s latency got=%0d exp=%0d", name, lat, exp_lat(a, b));
    end
    total++;
    if (mul_if.product !== exp_p) begin
      bad++;
      $display("FAIL %s product a=%h b=%h s=%b got=%h exp=%h",
               name, a, b, s, mul_if.product, exp_p);
    end
    total++;
    if (bs !== (exp_lat(a, b) != 0) || mul_if.busy !== 1'b0) begin
      bad++;
      $display("FAIL %s busy seen=%b at_done=%b exp_seen=%b",
               name, bs, mul_if.busy, exp_lat(a, b) != 0);
    end
  endtask

  task automatic test_reset;
    clr = 1'b1;
    mul_if.start = 1'b1;
    mul_if.multiplicand = 32'd5;
    mul_if.multiplier = 32'd6;
    mul_if.signed_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({mul_if.busy, mul_if.done} !== 2'b00 || mul_if.product !== 64'd0) begin
      bad++;
      $display("FAIL reset busy=%b done=%b product=%h exp 0/0/0",
               mul_if.busy, mul_if.done, mul_if.product);
    end
    mul_if.start = 1'b0;
    clr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed;
    run_op(32'd7, 32'hFFFF_FFFD, 1'b1, "s_7x-3");
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, "s_min_min");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "s_m1_m1");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "u_max_max");
    run_op(32'h8000_0000, 32'd2, 1'b0, "u_msb_x2");
    run_op(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, "s_max_min");
    run_op(32'd0, 32'h1234_5678, 1'b1, "zero_m");
    run_op(32'h1234_5678, 32'd0, 1'b0, "zero_q");
  endtask

  task automatic test_random;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      if ($urandom_range(0, 7) == 0) b = 32'hFFFF_FFFF;
      if ($urandom_range(0, 15) == 0) b = 32'd0;
      run_op(a, b, 1'($urandom), "random");
    end
  endtask

  task automatic test_ignore_start;
    int   lat;
    logic [63:0] exp_p;
    exp_p = ref_mul(32'd1000, 32'hFFFF_FF00, 1'b1);
    accept(32'd1000, 32'hFFFF_FF00, 1'b1);
    lat = 0;
    while (mul_if.done !== 1'b1 && lat < 60) begin
      mul_if.start = (lat == 5);
      mul_if.multiplicand = 32'd3;
      mul_if.multiplier = 32'd9;
      @(posedge clk);
      #1;
      lat++;
    end
    mul_if.start = 1'b0;
    total++;
    if (lat !== NLAT || mul_if.product !== exp_p) begin
      bad++;
      $display("FAIL ignore_start lat=%0d product=%h exp lat=%0d product=%h",
               lat, mul_if.product, NLAT, exp_p);
    end
    @(posedge clk);
    #1;
    total++;
    if (mul_if.busy !== 1'b0 || mul_if.done !== 1'b0 || mul_if.product !== exp_p) begin
      bad++;
      $display("FAIL hold busy=%b done=%b product=%h exp 0/0/%h",
               mul_if.busy, mul_if.done, mul_if.product, exp_p);
    end
  endtask

  task automatic test_back_to_back;
    int   lat;
    logic bs;
    logic [63:0] exp_p;
    accept(32'h0001_0001, 32'h0000_FFFF, 1'b0);
    wait_done(lat, bs);
    exp_p = ref_mul(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1);
    accept(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1);
    total++;
    if (mul_if.busy !== 1'b1 || mul_if.done !== 1'b0) begin
      bad++;
      $display("FAIL b2b_accept busy=%b done=%b exp 1/0", mul_if.busy, mul_if.done);
    end
    wait_done(lat, bs);
    total++;
    if (lat !== NLAT || mul_if.product !== exp_p) begin
      bad++;
      $display("FAIL b2b_second lat=%0d product=%h exp lat=%0d product=%h",
               lat, mul_if.product, NLAT, exp_p);
    end
  endtask

  task automatic test_clr_midrun;
    int seen;
    accept(32'h1111_1111, 32'h2222_2222, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    total++;
    if ({mul_if.busy, mul_if.done} !== 2'b00 || mul_if.product !== 64'd0) begin
      bad++;
      $display("FAIL clr_midrun busy=%b done=%b product=%h exp 0/0/0",
               mul_if.busy, mul_if.done, mul_if.product);
    end
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (mul_if.done === 1'b1 || mul_if.busy === 1'b1) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL clr_no_done activity_cycles=%0d exp=0", seen);
    end
    run_op(32'hFFFF_FFF0, 32'd16, 1'b1, "after_clr");
  endtask

  initial begin
    total = 0;
    bad = 0;
    clr = 1'b0;
    mul_if.start = 1'b0;
    mul_if.signed_mode = 1'b0;
    mul_if.multiplicand = '0;
    mul_if.multiplier = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_clr_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
